spi_page_loader: RTL and testbench
==================================

SPI_PAGE_LOADER -- requirements
Module: spi_page_loader

Interface
REQ-001 Parameter PAGE_BYTES, 128, bytes per flash page; power of two, 16..512, SHALL be supported.
REQ-002 Parameter WORD_BITS, 2, bits per buffer write word; values 1, 2, 4 and 8 SHALL be supported.
REQ-003 Parameter CLK_HALF, 1, master_clock cycles per SPI CLK half-period; any value >=1 SHALL be supported.
REQ-004 Parameter BOOT_PAGE, 12'h805, page number read on a bootloader load.
REQ-005 Parameter BOOT_PAGES, 4, consecutive pages read on a bootloader load.
REQ-006 Derived AW = clog2(BOOT_PAGES*PAGE_BYTES*8/WORD_BITS) SHALL set the buf_addr width.
REQ-007 master_clock  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 image_number  in  3  flash image select.
REQ-010 page_number  in  12  page to load.
REQ-011 load_page  in  1  start a single-page load.
REQ-012 load_bootloader  in  1  start a BOOT_PAGES-page load from BOOT_PAGE.
REQ-013 busy  out  1  transfer in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 buf_addr  out  AW  buffer write address.
REQ-016 buf_data  out  WORD_BITS  buffer write data.
REQ-017 buf_we  out  1  one-cycle buffer write strobe.
REQ-018 CS, CLK, MOSI  out  1 each; MISO  in  1; W25Q-series flash pins.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, CMD, DUMMY, DATA, FINISH, DONE.
REQ-020 IDLE SHALL accept a start when load_page or load_bootloader is high; when both are high, bootloader SHALL win; starts while busy SHALL be ignored.
REQ-021 On accept, the FSM SHALL latch image_number and the page (page_number or BOOT_PAGE), enter SETUP, and drive CS low and busy high on the next cycle.
REQ-022 Flash byte address SHALL be (image_number*4096 + page)*PAGE_BYTES, truncated to 24 bits.
REQ-023 SPI SHALL be mode 3: CLK idles high; MOSI changes after each CLK falling edge; MISO is sampled on each CLK rising edge.
REQ-024 Each CLK level SHALL last exactly CLK_HALF cycles; SETUP and FINISH SHALL each last one half-period.
REQ-025 CMD SHALL shift the 8-bit read command and then the 24-bit address, MSB first.
REQ-026 MOSI SHALL be 0 outside CMD.
REQ-027 DATA length SHALL be PAGE_BYTES*8 bits for a page load and BOOT_PAGES*PAGE_BYTES*8 bits for a bootloader load, read in one CS transaction across page boundaries.
REQ-028 Received bits SHALL pack MSB first: the first bit of each word goes to buf_data[WORD_BITS-1].
REQ-029 After every WORD_BITS bits, buf_we SHALL pulse one cycle with stable buf_data and buf_addr.
REQ-030 buf_addr SHALL be 0 for the first write, increment after each write, and end at (words-1) without wrapping.
REQ-031 FINISH SHALL drive CLK and CS high; DONE SHALL pulse done one cycle, drop busy, and return to IDLE.
REQ-032 A start input held high after DONE SHALL begin a new transfer.

Reset
REQ-033 Reset values SHALL be: CS=1, CLK=1, MOSI=0, busy=0, done=0, buf_we=0, buf_addr=0, buf_data=0, state IDLE.
REQ-034 Reset in any state SHALL abort the transfer; CS SHALL be high on the next cycle, and no done or further buf_we SHALL be issued.

Configuration
REQ-035 Macro SPI_FAST_READ_EN SHALL select the read mode.
REQ-036 With SPI_FAST_READ_EN defined, command SHALL be 0x0B and DUMMY SHALL insert 8 CLK cycles with MOSI=0 before DATA.
REQ-037 With SPI_FAST_READ_EN undefined, command SHALL be 0x03 and DUMMY SHALL be skipped.

Verification
REQ-038 Defaults, image 3, page 0x123, flash byte i=i&0xFF: MOSI shows 0x03, 0x189180; 512 buf_we pulses; word k = (byte[k/4] >> (6-2*(k%4)))&3; one done.
REQ-039 load_bootloader, image 0: address 0x040280; 2048 writes; last buf_addr 2047; CS low throughout.
REQ-040 load_page and load_bootloader raised in the same cycle: bootloader address 0x040280 is used.
REQ-041 Reset asserted at the 100th buf_we: CS=1 next cycle, no done; a following page load completes with 512 writes from buf_addr 0.
REQ-042 CLK_HALF=3, WORD_BITS=8: every CLK level lasts 3 cycles; 128 writes with buf_data equal to the flash bytes.
REQ-043 SPI_FAST_READ_EN defined, REQ-038 stimulus: command 0x0B, 8 dummy clocks, buffer contents identical to REQ-038.

Source files
------------

// File: rtl/spi_page_loader.sv
`default_nettype none
// ============================================================================
//  Module   : spi_page_loader
//  Function : Reads one flash page, or a run of bootloader pages, from a
//             W25Q-series SPI flash in mode 3. Received bits are packed into
//             WORD_BITS-wide buffer writes.
//  Options  : SPI_FAST_READ_EN selects Fast Read (0x0B plus 8 dummy clocks).
//             When it is undefined, plain Read (0x03) is used.
//  Revision : 1.0  initial release
// ============================================================================
module spi_page_loader #(
    parameter int          PAGE_BYTES = 128,
    parameter int          WORD_BITS  = 2,
    parameter int          CLK_HALF   = 1,
    parameter logic [11:0] BOOT_PAGE  = 12'h805,
    parameter int          BOOT_PAGES = 4,
    localparam int         AW         = $clog2(BOOT_PAGES*PAGE_BYTES*8/WORD_BITS)
) (
    input  logic                 master_clock,
    input  logic                 reset,
    input  logic [2:0]           image_number,
    input  logic [11:0]          page_number,
    input  logic                 load_page,
    input  logic                 load_bootloader,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        buf_addr,
    output logic [WORD_BITS-1:0] buf_data,
    output logic                 buf_we,
    output logic                 CS,
    output logic                 CLK,
    output logic                 MOSI,
    input  logic                 MISO
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] c_READ_CMD = 8'h0B;
    localparam logic       c_FAST     = 1'b1;
`else
    localparam logic [7:0] c_READ_CMD = 8'h03;
    localparam logic       c_FAST     = 1'b0;
`endif

    localparam int c_PAGE_BITS = PAGE_BYTES * 8;
    localparam int c_BOOT_BITS = BOOT_PAGES * PAGE_BYTES * 8;
    localparam int c_BCW       = $clog2(c_BOOT_BITS + 40);
    localparam int c_HCW       = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int c_WCW       = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int c_PSH       = $clog2(PAGE_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_CMD    = 3'd2,
        S_DUMMY  = 3'd3,
        S_DATA   = 3'd4,
        S_FINISH = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                 state_q,    state_d;
    logic [c_HCW-1:0]       hcnt_q,     hcnt_d;
    logic                   clk_q,      clk_d;
    logic                   cs_q,       cs_d;
    logic                   mosi_q,     mosi_d;
    logic [31:0]            shreg_q,    shreg_d;
    logic [c_BCW-1:0]       bitcnt_q,   bitcnt_d;
    logic                   boot_q,     boot_d;
    logic [WORD_BITS-1:0]   word_q,     word_d;
    logic [c_WCW-1:0]       wcnt_q,     wcnt_d;
    logic [AW-1:0]          widx_q,     widx_d;
    logic [AW-1:0]          buf_addr_q, buf_addr_d;
    logic [WORD_BITS-1:0]   buf_data_q, buf_data_d;
    logic                   buf_we_q,   buf_we_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;

    logic                   w_tick;
    logic                   w_last_bit;
    logic [11:0]            w_page;
    logic [23:0]            w_start_addr;
    logic [WORD_BITS-1:0]   w_word_next;

    assign w_tick       = (hcnt_q == c_HCW'(CLK_HALF - 1));
    assign w_last_bit   = boot_q ? (bitcnt_q == c_BCW'(c_BOOT_BITS - 1))
                                 : (bitcnt_q == c_BCW'(c_PAGE_BITS - 1));
    assign w_page       = load_bootloader ? BOOT_PAGE : page_number;
    // (image*4096 + page) * PAGE_BYTES; the 24-bit shift drops overflow bits
    assign w_start_addr = {9'd0, image_number, w_page} << c_PSH;
    assign w_word_next  = WORD_BITS'({word_q, MISO});

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        clk_d      = clk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        boot_d     = boot_q;
        word_d     = word_q;
        wcnt_d     = wcnt_q;
        widx_d     = widx_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_we_d   = 1'b0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            hcnt_d = w_tick ? '0 : hcnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                clk_d  = 1'b1;
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                hcnt_d = '0;
                if (load_page || load_bootloader) begin
                    boot_d   = load_bootloader;
                    shreg_d  = {c_READ_CMD, w_start_addr};
                    bitcnt_d = '0;
                    wcnt_d   = '0;
                    widx_d   = '0;
                    word_d   = '0;
                    cs_d     = 1'b0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    clk_d   = 1'b0;
                    mosi_d  = shreg_q[31];
                    shreg_d = {shreg_q[30:0], 1'b0};
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (w_tick) begin
                    if (!clk_q) begin
                        clk_d = 1'b1;
                    end else if (bitcnt_q == c_BCW'(31)) begin
                        clk_d    = 1'b0;
                        mosi_d   = 1'b0;
                        bitcnt_d = '0;
                        state_d  = c_FAST ? S_DUMMY : S_DATA;
                    end else begin
                        clk_d    = 1'b0;
                        mosi_d   = shreg_q[31];
                        shreg_d  = {shreg_q[30:0], 1'b0};
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            S_DUMMY: begin
                if (w_tick) begin
                    if (!clk_q) begin
                        clk_d = 1'b1;
                    end else begin
                        clk_d = 1'b0;
                        if (bitcnt_q == c_BCW'(7)) begin
                            bitcnt_d = '0;
                            state_d  = S_DATA;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (!clk_q) begin
                        // rising edge: MISO has been stable for a full low level
                        clk_d  = 1'b1;
                        word_d = w_word_next;
                        if (wcnt_q == c_WCW'(WORD_BITS - 1)) begin
                            wcnt_d     = '0;
                            buf_we_d   = 1'b1;
                            buf_data_d = w_word_next;
                            buf_addr_d = widx_q;
                            widx_d     = widx_q + 1'b1;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end else if (w_last_bit) begin
                        cs_d    = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        clk_d    = 1'b0;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                clk_d = 1'b1;
                cs_d  = 1'b1;
                if (w_tick) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                hcnt_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hcnt_q     <= '0;
            clk_q      <= 1'b1;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            boot_q     <= 1'b0;
            word_q     <= '0;
            wcnt_q     <= '0;
            widx_q     <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            clk_q      <= clk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            boot_q     <= boot_d;
            word_q     <= word_d;
            wcnt_q     <= wcnt_d;
            widx_q     <= widx_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_we_q   <= buf_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;
    assign buf_we   = buf_we_q;
    assign CS       = cs_q;
    assign CLK      = clk_q;
    assign MOSI     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_page_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_page_loader
//  Function : Directed bench for spi_page_loader with a behavioural W25Q flash
//             (byte at address i reads as i & 0xFF). Honours SPI_FAST_READ_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_page_loader;

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] c_EXP_CMD = 8'h0B;
    localparam int         c_HDR     = 40;
`else
    localparam logic [7:0] c_EXP_CMD = 8'h03;
    localparam int         c_HDR     = 32;
`endif

    logic        master_clock = 1'b0;
    logic        reset        = 1'b1;
    logic [2:0]  image_number = '0;
    logic [11:0] page_number  = '0;
    logic        load_page    = 1'b0;
    logic        load_bootloader = 1'b0;
    logic        sel          = 1'b0;
    logic        miso_r       = 1'b0;

    logic        busy1, done1, we1, cs1, clk1, mosi1;
    logic [10:0] addr1;
    logic [1:0]  data1;
    logic        busy2, done2, we2, cs2, clk2, mosi2;
    logic [8:0]  addr2;
    logic [7:0]  data2;

    always #5 master_clock = ~master_clock;

    spi_page_loader u_dut1 (
        .master_clock(master_clock), .reset(reset),
        .image_number(image_number), .page_number(page_number),
        .load_page(load_page & ~sel), .load_bootloader(load_bootloader & ~sel),
        .busy(busy1), .done(done1), .buf_addr(addr1), .buf_data(data1), .buf_we(we1),
        .CS(cs1), .CLK(clk1), .MOSI(mosi1), .MISO(miso_r)
    );

    spi_page_loader #(.CLK_HALF(3), .WORD_BITS(8)) u_dut2 (
        .master_clock(master_clock), .reset(reset),
        .image_number(image_number), .page_number(page_number),
        .load_page(load_page & sel), .load_bootloader(load_bootloader & sel),
        .busy(busy2), .done(done2), .buf_addr(addr2), .buf_data(data2), .buf_we(we2),
        .CS(cs2), .CLK(clk2), .MOSI(mosi2), .MISO(miso_r)
    );

    wire        cs_m   = sel ? cs2   : cs1;
    wire        clk_m  = sel ? clk2  : clk1;
    wire        mosi_m = sel ? mosi2 : mosi1;
    wire        busy_m = sel ? busy2 : busy1;
    wire        done_m = sel ? done2 : done1;
    wire        we_m   = sel ? we2   : we1;
    wire [10:0] addr_m = sel ? {2'b00, addr2} : addr1;
    wire [7:0]  data_m = sel ? data2 : {6'd0, data1};

    // behavioural flash: samples MOSI on CLK rise, shifts data out on CLK fall
    int          fl_rise = 0;
    int          fl_dout = 0;
    logic [31:0] fl_sh   = '0;
    logic [7:0]  fl_cmd  = '0;
    logic [23:0] fl_addr = '0;
    int          fl_mosi_bad = 0;

    always @(posedge cs_m) begin
        fl_rise = 0;
        fl_dout = 0;
    end

    always @(posedge clk_m) begin
        if (cs_m === 1'b0) begin
            fl_rise++;
            if (fl_rise <= 32) fl_sh = {fl_sh[30:0], mosi_m};
            else if (mosi_m !== 1'b0) fl_mosi_bad++;
            if (fl_rise == 8)  fl_cmd  = fl_sh[7:0];
            if (fl_rise == 32) fl_addr = fl_sh[23:0];
        end
    end

    always @(negedge clk_m) begin
        logic [7:0] b;
        int hdr;
        if (cs_m === 1'b0) begin
            hdr = (fl_cmd == 8'h0B) ? 40 : 32;
            if (fl_rise >= hdr) begin
                b = fl_addr[7:0] + 8'(fl_dout / 8);
                miso_r = b[7 - (fl_dout % 8)];
                fl_dout++;
            end
        end
    end

    // buffer-write and bus-timing monitor
    logic [23:0] exp_base = '0;
    int   wr_cnt = 0, wr_bad = 0, xfer_idx = 0, done_cnt = 0, cs_rise = 0;
    int   clk_len_bad = 0, run = 0;
    logic [10:0] last_addr = '0;
    logic cs_prev = 1'b1, clk_prev = 1'b1;

    always @(negedge master_clock) begin
        int mwb, sh;
        logic [7:0] eb, ew;
        if (cs_m === 1'b0 && cs_prev === 1'b1) xfer_idx = 0;
        if (cs_m === 1'b1 && cs_prev === 1'b0) cs_rise++;
        if (cs_m === 1'b0) begin
            if (clk_m !== clk_prev) begin
                if (run != (sel ? 3 : 1)) clk_len_bad++;
                run = 1;
            end else begin
                run++;
            end
        end else begin
            run = 0;
        end
        cs_prev  = cs_m;
        clk_prev = clk_m;
        if (done_m === 1'b1) done_cnt++;
        if (we_m === 1'b1) begin
            mwb = sel ? 8 : 2;
            eb  = exp_base[7:0] + 8'((xfer_idx * mwb) / 8);
            sh  = 8 - mwb - mwb * (xfer_idx % (8 / mwb));
            ew  = (eb >> sh) & 8'((1 << mwb) - 1);
            if (addr_m !== 11'(xfer_idx)) wr_bad++;
            if (data_m !== ew) wr_bad++;
            last_addr = addr_m;
            wr_cnt++;
            xfer_idx++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic clear_mon();
        wr_cnt = 0; wr_bad = 0; done_cnt = 0; cs_rise = 0;
        clk_len_bad = 0; fl_mosi_bad = 0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge master_clock);
            if (done_m === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input bit boot, input bit page, input logic [2:0] img,
                               input logic [11:0] pg);
        @(negedge master_clock);
        image_number = img; page_number = pg;
        load_bootloader = boot; load_page = page;
        @(negedge master_clock);
        load_bootloader = 1'b0; load_page = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge master_clock);
        reset = 1'b0;
        @(negedge master_clock);
        n_cmp++; if (cs1 !== 1'b1)    begin n_bad++; $display("FAIL reset_cs got %b want 1", cs1); end
        n_cmp++; if (clk1 !== 1'b1)   begin n_bad++; $display("FAIL reset_clk got %b want 1", clk1); end
        n_cmp++; if (mosi1 !== 1'b0)  begin n_bad++; $display("FAIL reset_mosi got %b want 0", mosi1); end
        n_cmp++; if (busy1 !== 1'b0)  begin n_bad++; $display("FAIL reset_busy got %b want 0", busy1); end
        n_cmp++; if (done1 !== 1'b0)  begin n_bad++; $display("FAIL reset_done got %b want 0", done1); end
        n_cmp++; if (we1 !== 1'b0)    begin n_bad++; $display("FAIL reset_we got %b want 0", we1); end
        n_cmp++; if (addr1 !== 11'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", addr1); end
        n_cmp++; if (data1 !== 2'd0)  begin n_bad++; $display("FAIL reset_data got %0d want 0", data1); end
    endtask

    task automatic test_page_load();
        bit ok;
        sel = 1'b0; exp_base = 24'h189180; clear_mon();
        pulse_start(1'b0, 1'b1, 3'd3, 12'h123);
        n_cmp++; if (busy1 !== 1'b1 || cs1 !== 1'b0) begin n_bad++; $display("FAIL page_start busy=%b cs=%b want 1/0", busy1, cs1); end
        wait_done(20000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL page_timeout done not seen"); end
        @(negedge master_clock);
        n_cmp++; if (fl_cmd !== c_EXP_CMD) begin n_bad++; $display("FAIL page_cmd got %h want %h", fl_cmd, c_EXP_CMD); end
        n_cmp++; if (fl_addr !== 24'h189180) begin n_bad++; $display("FAIL page_addr got %h want 189180", fl_addr); end
        n_cmp++; if (wr_cnt !== 512) begin n_bad++; $display("FAIL page_writes got %0d want 512", wr_cnt); end
        n_cmp++; if (wr_bad !== 0) begin n_bad++; $display("FAIL page_words bad=%0d want 0", wr_bad); end
        n_cmp++; if (last_addr !== 11'd511) begin n_bad++; $display("FAIL page_last_addr got %0d want 511", last_addr); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL page_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (fl_mosi_bad !== 0) begin n_bad++; $display("FAIL page_mosi_idle got %0d high bits want 0", fl_mosi_bad); end
        n_cmp++; if (fl_rise !== 0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL page_end cs_rise_reset=%0d busy=%b want 0/0", fl_rise, busy1); end
    endtask

    task automatic test_clock_count();
        bit ok;
        int rises;
        sel = 1'b0; exp_base = 24'h189180; clear_mon();
        pulse_start(1'b0, 1'b1, 3'd3, 12'h123);
        rises = 0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge master_clock);
            if (fl_rise > rises) rises = fl_rise;
            if (done_m === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL clocks_timeout done not seen"); end
        n_cmp++; if (rises !== c_HDR + 1024) begin n_bad++; $display("FAIL clocks_count got %0d want %0d", rises, c_HDR + 1024); end
    endtask

    task automatic test_bootloader(input bit with_page);
        bit ok;
        sel = 1'b0; exp_base = 24'h040280; clear_mon();
        pulse_start(1'b1, with_page, 3'd0, 12'h123);
        wait_done(30000, ok);
        @(negedge master_clock);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL boot_timeout done not seen"); end
        n_cmp++; if (fl_addr !== 24'h040280) begin n_bad++; $display("FAIL boot_addr got %h want 040280", fl_addr); end
        n_cmp++; if (wr_cnt !== 2048) begin n_bad++; $display("FAIL boot_writes got %0d want 2048", wr_cnt); end
        n_cmp++; if (wr_bad !== 0) begin n_bad++; $display("FAIL boot_words bad=%0d want 0", wr_bad); end
        n_cmp++; if (last_addr !== 11'd2047) begin n_bad++; $display("FAIL boot_last_addr got %0d want 2047", last_addr); end
        n_cmp++; if (cs_rise !== 1) begin n_bad++; $display("FAIL boot_cs_low got %0d cs rises want 1", cs_rise); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        sel = 1'b0; exp_base = 24'h189180; clear_mon();
        pulse_start(1'b0, 1'b1, 3'd3, 12'h123);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge master_clock);
            if (we1 === 1'b1 && addr1 === 11'd99) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_timeout 100th write not seen"); end
        reset = 1'b1;
        @(negedge master_clock);
        n_cmp++; if (cs1 !== 1'b1 || busy1 !== 1'b0) begin n_bad++; $display("FAIL abort_cs cs=%b busy=%b want 1/0", cs1, busy1); end
        repeat (2) @(negedge master_clock);
        reset = 1'b0;
        repeat (50) @(negedge master_clock);
        n_cmp++; if (done_cnt !== 0 || wr_cnt !== 100) begin n_bad++; $display("FAIL abort_quiet done=%0d writes=%0d want 0/100", done_cnt, wr_cnt); end
        clear_mon();
        pulse_start(1'b0, 1'b1, 3'd3, 12'h123);
        wait_done(20000, ok);
        @(negedge master_clock);
        n_cmp++; if (!ok || wr_cnt !== 512 || wr_bad !== 0) begin n_bad++; $display("FAIL abort_reload done=%b writes=%0d bad=%0d want 1/512/0", ok, wr_cnt, wr_bad); end
    endtask

    task automatic test_slow_wide();
        bit ok;
        sel = 1'b1; exp_base = 24'h189180; clear_mon();
        pulse_start(1'b0, 1'b1, 3'd3, 12'h123);
        wait_done(30000, ok);
        @(negedge master_clock);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL slow_timeout done not seen"); end
        n_cmp++; if (wr_cnt !== 128) begin n_bad++; $display("FAIL slow_writes got %0d want 128", wr_cnt); end
        n_cmp++; if (wr_bad !== 0) begin n_bad++; $display("FAIL slow_bytes bad=%0d want 0", wr_bad); end
        n_cmp++; if (clk_len_bad !== 0) begin n_bad++; $display("FAIL slow_clk_levels bad=%0d want 0", clk_len_bad); end
        n_cmp++; if (fl_cmd !== c_EXP_CMD) begin n_bad++; $display("FAIL slow_cmd got %h want %h", fl_cmd, c_EXP_CMD); end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok, ok2, rebusy;
        sel = 1'b0; exp_base = 24'h189180; clear_mon();
        @(negedge master_clock);
        image_number = 3'd3; page_number = 12'h123; load_page = 1'b1;
        wait_done(20000, ok);
        rebusy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge master_clock);
            if (busy1 === 1'b1) begin rebusy = 1'b1; break; end
        end
        load_page = 1'b0;
        n_cmp++; if (!ok || !rebusy) begin n_bad++; $display("FAIL b2b_restart done=%b busy_again=%b want 1/1", ok, rebusy); end
        wait_done(20000, ok2);
        @(negedge master_clock);
        n_cmp++; if (!ok2 || done_cnt !== 2) begin n_bad++; $display("FAIL b2b_done got %0d want 2", done_cnt); end
        n_cmp++; if (wr_cnt !== 1024 || wr_bad !== 0) begin n_bad++; $display("FAIL b2b_writes got %0d bad=%0d want 1024/0", wr_cnt, wr_bad); end
    endtask

    initial begin
        test_reset();
        test_page_load();
        test_clock_count();
        test_bootloader(1'b0);
        test_bootloader(1'b1);
        test_reset_abort();
        test_slow_wide();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
